// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types.
//   decoded_instruction_type : instruction class produced by the decoder in data_path.
//   Encodings 14 and 15 are unused and decode as illegal in control_unit.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

endpackage

// File: rtl/control_unit.sv
// control_unit: sequences the K&S data_path through fetch, decode, execute and PC update.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   decoded_instruction       instruction class from the IR decoder
//   zero_op, neg_op           datapath flags, valid the cycle after an ALU op
//   unsigned_overflow,
//   signed_overflow           datapath flags, only kept in the shadow register
//   branch, pc_enable         PC source select and PC load strobe
//   ir_enable                 instruction register load strobe
//   addr_sel                  1: ram_addr=PC, 0: ram_addr=mem_addr
//   c_sel                     1: bus_c=data_in, 0: bus_c=ALU
//   operation                 ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   write_reg_enable          register-file write strobe
//   flags_reg_enable          datapath flag-register load strobe
//   ram_write_enable          RAM write strobe
//   halt                      high while halted
//   illegal_instr             sticky unrecognised-decode indicator
//   retired_count             saturating retired-instruction count
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned LOAD_WAIT = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic                    illegal_instr,
    output logic [CNT_W-1:0]        retired_count
);

    localparam int unsigned WAIT_W = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_LOAD_WAIT, S_LOAD_WB, S_STORE,
        S_EXEC, S_NEXT, S_JUMP, S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                flag_op_q, flag_op_d;
    logic                pend_q, pend_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                z_q, n_q, uo_q, so_q;
    logic                z_d, n_d, uo_d, so_d;
    logic                illegal_d;
    logic [CNT_W-1:0]    ret_d;

    logic                branch_d, pc_enable_d, ir_enable_d, addr_sel_d, c_sel_d;
    logic [1:0]          operation_d;
    logic                write_reg_enable_d, flags_reg_enable_d, ram_write_enable_d, halt_d;

    // Overflow shadows are architectural state with no consumer in this block yet.
    logic unused_ovf;
    assign unused_ovf = &{1'b0, uo_q, so_q};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state, bookkeeping and output decode of the next state (outputs are registered).
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        flag_op_d = flag_op_q;
        pend_d    = pend_q;
        wait_d    = wait_q;
        z_d       = z_q;
        n_d       = n_q;
        uo_d      = uo_q;
        so_d      = so_q;
        illegal_d = illegal_q_int();
        ret_d     = retired_count;

        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (decoded_instruction)
                    I_NOP:    state_d = S_NEXT;
                    I_LOAD: begin
                        state_d = S_LOAD_WAIT;
                        wait_d  = WAIT_W'(LOAD_WAIT - 1);
                    end
                    I_STORE:  state_d = S_STORE;
                    I_MOVE:   begin state_d = S_EXEC; op_d = 2'b00; flag_op_d = 1'b0; end
                    I_ADD:    begin state_d = S_EXEC; op_d = 2'b01; flag_op_d = 1'b1; end
                    I_SUB:    begin state_d = S_EXEC; op_d = 2'b10; flag_op_d = 1'b1; end
                    I_AND:    begin state_d = S_EXEC; op_d = 2'b11; flag_op_d = 1'b1; end
                    I_OR:     begin state_d = S_EXEC; op_d = 2'b00; flag_op_d = 1'b1; end
                    I_BRANCH: state_d = S_JUMP;
                    I_BZERO:  state_d = z_q  ? S_JUMP : S_NEXT;
                    I_BNZERO: state_d = !z_q ? S_JUMP : S_NEXT;
                    I_BNEG:   state_d = n_q  ? S_JUMP : S_NEXT;
                    I_BNNEG:  state_d = !n_q ? S_JUMP : S_NEXT;
                    I_HALT:   state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_LOAD_WAIT: begin
                if (wait_q == '0) state_d = S_LOAD_WB;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_LOAD_WB: state_d = S_NEXT;
            S_STORE:   state_d = S_NEXT;
            S_EXEC: begin
                state_d = S_NEXT;
                pend_d  = flag_op_q;
            end
            S_NEXT: begin
                state_d = S_FETCH;
                // Flags from the preceding ALU op are valid now; data_path drops them next cycle.
                if (pend_q) begin
                    z_d    = zero_op;
                    n_d    = neg_op;
                    uo_d   = unsigned_overflow;
                    so_d   = signed_overflow;
                    pend_d = 1'b0;
                end
                if (retired_count != '1) ret_d = retired_count + CNT_W'(1);
            end
            S_JUMP: begin
                state_d = S_FETCH;
                if (retired_count != '1) ret_d = retired_count + CNT_W'(1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        branch_d           = 1'b0;
        pc_enable_d        = 1'b0;
        ir_enable_d        = 1'b0;
        addr_sel_d         = 1'b1;
        c_sel_d            = 1'b0;
        operation_d        = 2'b00;
        write_reg_enable_d = 1'b0;
        flags_reg_enable_d = 1'b0;
        ram_write_enable_d = 1'b0;
        halt_d             = 1'b0;

        case (state_d)
            S_FETCH:     ir_enable_d = 1'b1;
            S_LOAD_WAIT: addr_sel_d  = 1'b0;
            S_LOAD_WB: begin
                addr_sel_d         = 1'b0;
                c_sel_d            = 1'b1;
                write_reg_enable_d = 1'b1;
            end
            S_STORE: begin
                addr_sel_d         = 1'b0;
                ram_write_enable_d = 1'b1;
            end
            S_EXEC: begin
                write_reg_enable_d = 1'b1;
                operation_d        = op_d;
                flags_reg_enable_d = flag_op_d;
            end
            S_NEXT:  pc_enable_d = 1'b1;
            S_JUMP: begin
                pc_enable_d = 1'b1;
                branch_d    = 1'b1;
            end
            S_HALT:  halt_d = 1'b1;
            default: ;
        endcase
    end

    function automatic logic illegal_q_int();
        return illegal_instr;
    endfunction

    // Datapath bookkeeping and registered outputs; reset shows FETCH strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q             <= 2'b00;
            flag_op_q        <= 1'b0;
            pend_q           <= 1'b0;
            wait_q           <= '0;
            z_q              <= 1'b0;
            n_q              <= 1'b0;
            uo_q             <= 1'b0;
            so_q             <= 1'b0;
            illegal_instr    <= 1'b0;
            retired_count    <= '0;
            branch           <= 1'b0;
            pc_enable        <= 1'b0;
            ir_enable        <= 1'b1;
            addr_sel         <= 1'b1;
            c_sel            <= 1'b0;
            operation        <= 2'b00;
            write_reg_enable <= 1'b0;
            flags_reg_enable <= 1'b0;
            ram_write_enable <= 1'b0;
            halt             <= 1'b0;
        end else begin
            op_q             <= op_d;
            flag_op_q        <= flag_op_d;
            pend_q           <= pend_d;
            wait_q           <= wait_d;
            z_q              <= z_d;
            n_q              <= n_d;
            uo_q             <= uo_d;
            so_q             <= so_d;
            illegal_instr    <= illegal_d;
            retired_count    <= ret_d;
            branch           <= branch_d;
            pc_enable        <= pc_enable_d;
            ir_enable        <= ir_enable_d;
            addr_sel         <= addr_sel_d;
            c_sel            <= c_sel_d;
            operation        <= operation_d;
            write_reg_enable <= write_reg_enable_d;
            flags_reg_enable <= flags_reg_enable_d;
            ram_write_enable <= ram_write_enable_d;
            halt             <= halt_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction
// streams compared against a per-instruction cycle-sequence reference model.
module tb_control_unit;
    import k_and_s_pkg::*;

    localparam int unsigned LW   = 3;
    localparam int unsigned CW   = 6;
    localparam int          MAXC = (1 << CW) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable, flags_reg_enable, ram_write_enable;
    logic                    halt, illegal_instr;
    logic [CW-1:0]           retired_count;
    logic [10:0]             outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_ret;
    bit m_z, m_n, m_ill;

    control_unit #(.LOAD_WAIT(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .decoded_instruction(decoded_instruction),
        .zero_op(zero_op), .neg_op(neg_op),
        .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
        .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
        .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
        .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
        .ram_write_enable(ram_write_enable), .halt(halt),
        .illegal_instr(illegal_instr), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    assign outs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                   write_reg_enable, flags_reg_enable, ram_write_enable, halt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] vec(bit br, bit pc, bit ir, bit as, bit cs, logic [1:0] op,
                                        bit wr, bit fe, bit rw, bit h);
        return {br, pc, ir, as, cs, op, wr, fe, rw, h};
    endfunction

    function automatic logic [10:0] v_fetch();
        return vec(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    endfunction

    function automatic logic [10:0] v_halt();
        return vec(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 1);
    endfunction

    // Called at posedge+1; returns at posedge+1 with the FSM in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_outs", 32'(outs), 32'(v_fetch()));
        check("rst_ret", 32'(retired_count), 32'd0);
        check("rst_ill", 32'(illegal_instr), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        m_ret = 0;
        m_z   = 1'b0;
        m_n   = 1'b0;
        m_ill = 1'b0;
    endtask

    // Run one instruction from FETCH; the model builds the whole expected cycle sequence up front.
    task automatic run_instr(input decoded_instruction_type ins, input bit rnd,
                             input bit zi, input bit ni, input int hold);
        logic [10:0] seq[$];
        int  cap  = -1;
        bit  stop = 1'b0;
        bit  jmp  = 1'b0;
        bit  flg  = 1'b0;
        bit  cz   = 1'b0;
        bit  cn   = 1'b0;
        string nm;
        nm = $sformatf("i%0d", 32'(ins));
        check({nm, "_ret"}, 32'(retired_count), 32'(m_ret));
        check({nm, "_ill"}, 32'(illegal_instr), 32'(m_ill));
        seq.push_back(v_fetch());
        seq.push_back(vec(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
        case (ins)
            I_NOP: ;
            I_LOAD: begin
                for (int k = 0; k < int'(LW); k++) seq.push_back(vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
                seq.push_back(vec(0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0));
            end
            I_STORE:  seq.push_back(vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
            I_MOVE:   seq.push_back(vec(0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 0));
            I_ADD:    begin seq.push_back(vec(0, 0, 0, 1, 0, 2'b01, 1, 1, 0, 0)); flg = 1'b1; end
            I_SUB:    begin seq.push_back(vec(0, 0, 0, 1, 0, 2'b10, 1, 1, 0, 0)); flg = 1'b1; end
            I_AND:    begin seq.push_back(vec(0, 0, 0, 1, 0, 2'b11, 1, 1, 0, 0)); flg = 1'b1; end
            I_OR:     begin seq.push_back(vec(0, 0, 0, 1, 0, 2'b00, 1, 1, 0, 0)); flg = 1'b1; end
            I_BRANCH: jmp = 1'b1;
            I_BZERO:  jmp = m_z;
            I_BNZERO: jmp = !m_z;
            I_BNEG:   jmp = m_n;
            I_BNNEG:  jmp = !m_n;
            default:  stop = 1'b1;
        endcase
        if (!stop) begin
            seq.push_back(jmp ? vec(1, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0)
                              : vec(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0));
            if (flg) cap = seq.size() - 1;
        end

        decoded_instruction = ins;
        foreach (seq[i]) begin
            check($sformatf("%s_c%0d", nm, i), 32'(outs), 32'(seq[i]));
            zero_op           = rnd ? 1'($urandom) : zi;
            neg_op            = rnd ? 1'($urandom) : ni;
            unsigned_overflow = 1'($urandom);
            signed_overflow   = 1'($urandom);
            if (i == cap) begin
                cz = zero_op;
                cn = neg_op;
            end
            @(posedge clk); #1;
        end

        if (stop) begin
            m_ill = (ins != I_HALT);
            for (int k = 0; k < hold; k++) begin
                check({nm, "_halt"}, 32'(outs), 32'(v_halt()));
                check({nm, "_hill"}, 32'(illegal_instr), 32'(m_ill));
                @(posedge clk); #1;
            end
            check({nm, "_hret"}, 32'(retired_count), 32'(m_ret));
            do_reset();
        end else begin
            m_ret = (m_ret + 1 > MAXC) ? MAXC : m_ret + 1;
            if (cap >= 0) begin
                m_z = cz;
                m_n = cn;
            end
        end
    endtask

    // Reset asserted while EXEC strobes are active must clear them without a clock edge.
    task automatic abort_in_exec();
        decoded_instruction = I_ADD;
        check("abt_fetch", 32'(outs), 32'(v_fetch()));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abt_exec", 32'(outs), 32'(vec(0, 0, 0, 1, 0, 2'b01, 1, 1, 0, 0)));
        #2 rst = 1'b1;
        #1;
        check("abt_outs", 32'(outs), 32'(v_fetch()));
        check("abt_ret", 32'(retired_count), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        m_ret = 0;
        m_z   = 1'b0;
        m_n   = 1'b0;
        m_ill = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        decoded_instruction = I_NOP;
        zero_op             = 1'b0;
        neg_op              = 1'b0;
        unsigned_overflow   = 1'b0;
        signed_overflow     = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Directed scenarios
        run_instr(I_NOP,   0, 0, 0, 0);
        run_instr(I_ADD,   0, 1, 0, 0);
        run_instr(I_BZERO, 0, 0, 0, 0);
        run_instr(I_SUB,   0, 0, 1, 0);
        run_instr(I_NOP,   0, 0, 0, 0);
        run_instr(I_BNEG,  0, 0, 0, 0);
        run_instr(I_BNNEG, 0, 0, 0, 0);
        run_instr(I_MOVE,  0, 0, 0, 0);
        run_instr(I_BNEG,  0, 0, 0, 0);
        run_instr(I_LOAD,  0, 0, 0, 0);
        run_instr(I_STORE, 0, 0, 0, 0);
        run_instr(I_BRANCH, 0, 0, 0, 0);
        run_instr(I_OR,    0, 0, 0, 0);
        run_instr(I_BNZERO, 0, 0, 0, 0);
        run_instr(I_AND,   0, 0, 0, 0);

        // Long non-halting random stream drives the counter into saturation
        for (int k = 0; k < 80; k++)
            run_instr(decoded_instruction_type'(4'($urandom_range(0, 12))), 1, 0, 0, 0);
        check("sat", 32'(retired_count), 32'(MAXC));
        run_instr(I_NOP, 0, 0, 0, 0);
        check("sat_hold", 32'(retired_count), 32'(MAXC));

        abort_in_exec();
        run_instr(I_NOP, 0, 0, 0, 0);

        run_instr(decoded_instruction_type'(4'd15), 0, 0, 0, 5);
        run_instr(decoded_instruction_type'(4'd14), 0, 0, 0, 3);
        run_instr(I_HALT, 0, 0, 0, 100);

        // Mixed random stream including halts and illegal encodings
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 19) == 0)
                run_instr(decoded_instruction_type'(4'($urandom_range(13, 15))), 1, 0, 0, 4);
            else
                run_instr(decoded_instruction_type'(4'($urandom_range(0, 12))), 1, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
